// File: rtl/cfg_write_arbiter.sv
// Round-robin write arbiter that owns the five peripheral configuration registers.
// Optional saturating bad-address counter is enabled by defining CFG_ARB_ERR_CNT_EN.
module cfg_write_arbiter #(
  parameter int unsigned       ADDR_W     = 7,
  parameter logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(4),
  parameter logic [7:0]        DUTY_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_data,
  output logic              req1_ready,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              wr_strobe,
  output logic              bad_addr
`ifdef CFG_ARB_ERR_CNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_OUT_LO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_OUT_HI = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_PWM_LO = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_PWM_HI = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_DUTY   = ADDR_W'(4);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q;
  logic              grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              win1;
  logic              any_valid;
  logic              addr_ok;

  assign any_valid = req0_valid | req1_valid;
  // On a tie the port that did not win last time gets the grant.
  assign win1      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign addr_ok   = (addr_q <= MAX_ADDR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_valid) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= 1'b1;
      grant_q         <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      req0_ready      <= 1'b0;
      req1_ready      <= 1'b0;
      wr_strobe       <= 1'b0;
      bad_addr        <= 1'b0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= DUTY_RESET;
    end else begin
      state_q    <= state_d;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      wr_strobe  <= 1'b0;
      bad_addr   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            grant_q    <= win1;
            addr_q     <= win1 ? req1_addr : req0_addr;
            data_q     <= win1 ? req1_data : req0_data;
            req0_ready <= ~win1;
            req1_ready <= win1;
          end
        end
        ST_WRITE: begin
          last_grant_q <= grant_q;
          if (addr_ok) begin
            wr_strobe <= 1'b1;
            // Valid addresses with no backing register (MAX_ADDR > 4) are accepted silently.
            case (addr_q)
              ADDR_OUT_LO: en_reg_out_7_0  <= data_q;
              ADDR_OUT_HI: en_reg_out_15_8 <= data_q;
              ADDR_PWM_LO: en_reg_pwm_7_0  <= data_q;
              ADDR_PWM_HI: en_reg_pwm_15_8 <= data_q;
              ADDR_DUTY:   pwm_duty_cycle  <= data_q;
              default: ;
            endcase
          end else begin
            bad_addr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CFG_ARB_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'h00;
    end else if (state_q == ST_WRITE && !addr_ok && err_count != 8'hFF) begin
      err_count <= err_count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed self-checking bench for cfg_write_arbiter: vector table plus multi-cycle sequences.
module tb_cfg_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe, bad_addr;
`ifdef CFG_ARB_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_reg [5];

  always #5 clk = ~clk;

  cfg_write_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid      (req0_valid),
    .req0_addr       (req0_addr),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_addr       (req1_addr),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .bad_addr        (bad_addr)
`ifdef CFG_ARB_ERR_CNT_EN
    ,
    .err_count       (err_count)
`endif
  );

  typedef struct {
    bit         port;
    logic [6:0] addr;
    logic [7:0] data;
    bit         exp_bad;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_out_lo"}, 32'(en_reg_out_7_0), 32'(exp_reg[0]));
    chk({tag, "_out_hi"}, 32'(en_reg_out_15_8), 32'(exp_reg[1]));
    chk({tag, "_pwm_lo"}, 32'(en_reg_pwm_7_0), 32'(exp_reg[2]));
    chk({tag, "_pwm_hi"}, 32'(en_reg_pwm_15_8), 32'(exp_reg[3]));
    chk({tag, "_duty"}, 32'(pwm_duty_cycle), 32'(exp_reg[4]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
  endtask

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    if (a <= 7'h04) exp_reg[a[2:0]] = d;
  endtask

  task automatic drive(input bit port, input bit v, input logic [6:0] a, input logic [7:0] d);
    if (port) begin
      req1_valid = v; req1_addr = a; req1_data = d;
    end else begin
      req0_valid = v; req0_addr = a; req0_data = d;
    end
  endtask

  function automatic logic rdy(input bit port);
    return port ? req1_ready : req0_ready;
  endfunction

  // Entered at a negedge with the FSM idle; returns at a negedge with the FSM idle again.
  task automatic single(input bit port, input logic [6:0] a, input logic [7:0] d, input bit exp_bad);
    drive(port, 1'b1, a, d);
    @(negedge clk);
    chk("ready_win", 32'(rdy(port)), 32'd1);
    chk("ready_other", 32'(rdy(~port)), 32'd0);
    chk("strobe_early", 32'({wr_strobe, bad_addr}), 32'd0);
    drive(port, 1'b0, a, d);
    @(negedge clk);
    if (!exp_bad) model_write(a, d);
    chk("ready_gap", 32'({req1_ready, req0_ready}), 32'd0);
    chk("wr_strobe", 32'(wr_strobe), 32'(!exp_bad));
    chk("bad_addr", 32'(bad_addr), 32'(exp_bad));
    chk_regs("single");
    @(negedge clk);
    chk("idle_pulses", 32'({wr_strobe, bad_addr, req1_ready, req0_ready}), 32'd0);
  endtask

  // Both ports request together; 'first' is the expected winner.
  task automatic both(input bit first, input logic [6:0] a0, input logic [7:0] d0,
                      input logic [6:0] a1, input logic [7:0] d1);
    logic [6:0] fa, sa;
    logic [7:0] fd, sd;
    fa = first ? a1 : a0; fd = first ? d1 : d0;
    sa = first ? a0 : a1; sd = first ? d0 : d1;
    drive(1'b0, 1'b1, a0, d0);
    drive(1'b1, 1'b1, a1, d1);
    @(negedge clk);
    chk("both_first_ready", 32'(rdy(first)), 32'd1);
    chk("both_second_wait", 32'(rdy(~first)), 32'd0);
    drive(first, 1'b0, fa, fd);
    @(negedge clk);
    model_write(fa, fd);
    chk("both_strobe1", 32'(wr_strobe), 32'd1);
    chk("both_gap_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk_regs("both1");
    @(negedge clk);
    chk("both_idle_ready", 32'({req1_ready, req0_ready}), 32'd0);
    @(negedge clk);
    chk("both_second_ready", 32'(rdy(~first)), 32'd1);
    chk("both_first_quiet", 32'(rdy(first)), 32'd0);
    drive(~first, 1'b0, sa, sd);
    @(negedge clk);
    model_write(sa, sd);
    chk("both_strobe2", 32'(wr_strobe), 32'd1);
    chk_regs("both2");
    @(negedge clk);
    chk("both_end", 32'({wr_strobe, bad_addr, req1_ready, req0_ready}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 7'h04, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 7'h05, 8'hFF, 1'b1};
    vecs[2] = '{1'b0, 7'h02, 8'h5A, 1'b0};
    vecs[3] = '{1'b1, 7'h03, 8'hC3, 1'b0};
    vecs[4] = '{1'b0, 7'h7F, 8'h12, 1'b1};
    vecs[5] = '{1'b1, 7'h44, 8'h99, 1'b1};  // low bits alias 0x04, must be rejected
    vecs[6] = '{1'b0, 7'h00, 8'h01, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 7'h00, 8'h00);
    drive(1'b1, 1'b0, 7'h00, 8'h00);
    model_reset();
    repeat (3) @(negedge clk);
    chk_regs("reset");
    chk("reset_pulses", 32'({wr_strobe, bad_addr, req1_ready, req0_ready}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_ready", 32'({wr_strobe, bad_addr, req1_ready, req0_ready}), 32'd0);
`ifdef CFG_ARB_ERR_CNT_EN
    chk("err_count_reset", 32'(err_count), 32'd0);
`endif

    // Tie straight after reset goes to port 0.
    both(1'b0, 7'h00, 8'h11, 7'h01, 8'h22);
    // Solo port 0 write leaves port 0 as last grant, so the next tie goes to port 1.
    single(1'b0, 7'h03, 8'h77, 1'b0);
    both(1'b1, 7'h00, 8'h33, 7'h01, 8'h44);

    for (int i = 0; i < 7; i++) begin
      single(vecs[i].port, vecs[i].addr, vecs[i].data, vecs[i].exp_bad);
`ifdef CFG_ARB_ERR_CNT_EN
      if (i == 1) chk("err_count_one", 32'(err_count), 32'd1);
`endif
    end

    // Reset during WRITE of 0x02 <- 0x3C.
    drive(1'b0, 1'b1, 7'h02, 8'h3C);
    @(negedge clk);
    chk("rst_mid_ready", 32'(req0_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_regs("rst_mid");
    chk("rst_mid_pulses", 32'({wr_strobe, bad_addr, req1_ready, req0_ready}), 32'd0);
    drive(1'b0, 1'b0, 7'h02, 8'h3C);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({wr_strobe, bad_addr, req1_ready, req0_ready}), 32'd0);
      chk("post_rst_pwm_lo", 32'(en_reg_pwm_7_0), 32'd0);
    end
    single(1'b0, 7'h02, 8'h3C, 1'b0);

    // Port 0 holds valid continuously; data changes right after each grant.
    drive(1'b0, 1'b1, 7'h04, 8'h10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_ready", 32'(req0_ready), 32'd1);
      drive(1'b0, (k != 3), 7'h04, 8'(8'h11 + k));
      @(negedge clk);
      model_write(7'h04, 8'(8'h10 + k));
      chk("cont_gap_ready", 32'(req0_ready), 32'd0);
      chk("cont_strobe", 32'(wr_strobe), 32'd1);
      chk("cont_duty", 32'(pwm_duty_cycle), 32'(exp_reg[4]));
      @(negedge clk);
      chk("cont_idle_ready", 32'(req0_ready), 32'd0);
    end
    @(negedge clk);
    chk("cont_no_double", 32'({req1_ready, req0_ready}), 32'd0);
    chk_regs("cont_end");

`ifdef CFG_ARB_ERR_CNT_EN
    for (int i = 0; i < 300; i++) single(1'b1, 7'h05, 8'hFF, 1'b1);
    chk("err_count_sat", 32'(err_count), 32'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
